// File: rtl/cmpxchg_seq.sv
// cmpxchg_seq: execute-stage sequencer for CMPXCHG, in both the register-destination
// and memory-destination forms. The memory form runs a locked read-compare-write on
// the data-memory port.
//
// State    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; busy=0
// RD_REQ   | locked read request held until mem_ready
// RD_WAIT  | lock held, waiting for mem_rvalid to capture dest
// CMP      | compare acc vs dest, compute flags and results
// WR_REQ   | locked write of new dest, held until mem_ready
// DONE     | one-cycle completion pulse with writeback enables
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start, size, dest_is_mem       launch pulse and operation attributes
//   reg_dest, src, acc_in, addr    operands, latched on start
//   busy, done                     stall / completion pulse
//   zf_out, cf_out, sf_out, of_out flags of acc - dest at operand size
//   acc_we/acc_out, reg_we/reg_out writebacks (valid with done)
//   mem_req/we/lock/addr/wdata/size, mem_ready/rvalid/rdata  data-memory port
module cmpxchg_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic              dest_is_mem,
    input  logic [DATA_W-1:0] reg_dest,
    input  logic [DATA_W-1:0] src,
    input  logic [DATA_W-1:0] acc_in,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              zf_out,
    output logic              cf_out,
    output logic              sf_out,
    output logic              of_out,
    output logic              acc_we,
    output logic [DATA_W-1:0] acc_out,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_CMP, S_WR_REQ, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] dest_q, dest_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_mem_q, is_mem_d;
    logic              zf_q, zf_d, cf_q, cf_d, sf_q, sf_d, of_q, of_d;
    logic [DATA_W-1:0] acc_out_q, acc_out_d;
    logic [DATA_W-1:0] reg_out_q, reg_out_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W:0]   diff_full;
    logic [DATA_W-1:0] diff;
    logic              cmp_zf, cmp_cf, cmp_sf, cmp_of;

    // size 11 is treated as 32-bit
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
        logic [DATA_W-1:0] m;
        m = '0;
        case (sz)
            2'b00:   m[7:0]  = '1;
            2'b01:   m[15:0] = '1;
            default: m[31:0] = '1;
        endcase
        return m;
    endfunction

    function automatic logic msb_of(input logic [DATA_W-1:0] v, input logic [1:0] sz);
        logic b;
        case (sz)
            2'b00:   b = v[7];
            2'b01:   b = v[15];
            default: b = v[31];
        endcase
        return b;
    endfunction

    // Operands are masked when latched, so the borrow out of the full-width
    // subtraction equals the borrow out of the operand-size msb.
    always_comb begin
        diff_full = {1'b0, acc_q} - {1'b0, dest_q};
        diff      = diff_full[DATA_W-1:0] & size_mask(size_q);
        cmp_zf    = (diff == '0);
        cmp_cf    = diff_full[DATA_W];
        cmp_sf    = msb_of(diff, size_q);
        cmp_of    = (msb_of(acc_q, size_q) != msb_of(dest_q, size_q)) &&
                    (cmp_sf != msb_of(acc_q, size_q));
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        src_d     = src_q;
        acc_d     = acc_q;
        dest_d    = dest_q;
        addr_d    = addr_q;
        is_mem_d  = is_mem_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        sf_d      = sf_q;
        of_d      = of_q;
        acc_out_d = acc_out_q;
        reg_out_d = reg_out_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d   = size;
                    src_d    = src & size_mask(size);
                    acc_d    = acc_in & size_mask(size);
                    dest_d   = reg_dest & size_mask(size);
                    addr_d   = addr;
                    is_mem_d = dest_is_mem;
                    state_d  = dest_is_mem ? S_RD_REQ : S_CMP;
                end
            end
            S_RD_REQ: begin
                if (mem_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    dest_d  = mem_rdata & size_mask(size_q);
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                zf_d = cmp_zf;
                cf_d = cmp_cf;
                sf_d = cmp_sf;
                of_d = cmp_of;
                if (cmp_zf) begin
                    wdata_d   = src_q;
                    reg_out_d = src_q;
                    acc_out_d = acc_q;
                end else begin
                    wdata_d   = dest_q;
                    reg_out_d = dest_q;
                    acc_out_d = dest_q;
                end
                state_d = is_mem_q ? S_WR_REQ : S_DONE;
            end
            S_WR_REQ: begin
                if (mem_ready) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            src_q     <= '0;
            acc_q     <= '0;
            dest_q    <= '0;
            addr_q    <= '0;
            is_mem_q  <= 1'b0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            sf_q      <= 1'b0;
            of_q      <= 1'b0;
            acc_out_q <= '0;
            reg_out_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            src_q     <= src_d;
            acc_q     <= acc_d;
            dest_q    <= dest_d;
            addr_q    <= addr_d;
            is_mem_q  <= is_mem_d;
            zf_q      <= zf_d;
            cf_q      <= cf_d;
            sf_q      <= sf_d;
            of_q      <= of_d;
            acc_out_q <= acc_out_d;
            reg_out_q <= reg_out_d;
            wdata_q   <= wdata_d;
        end
    end

    // Control outputs decode straight from the state flop.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_req   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign mem_we    = (state_q == S_WR_REQ);
    assign mem_lock  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                       (state_q == S_WR_REQ) || ((state_q == S_CMP) && is_mem_q);
    assign acc_we    = done && !zf_q;
    assign reg_we    = done && zf_q && !is_mem_q;
    assign zf_out    = zf_q;
    assign cf_out    = cf_q;
    assign sf_out    = sf_q;
    assign of_out    = of_q;
    assign acc_out   = acc_out_q;
    assign reg_out   = reg_out_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

endmodule

// File: tb/tb_cmpxchg_seq.sv
module tb_cmpxchg_seq;

    logic        clk, rst_n, start, dest_is_mem;
    logic [1:0]  size;
    logic [31:0] reg_dest, src, acc_in, addr;
    logic        busy, done, zf_out, cf_out, sf_out, of_out, acc_we, reg_we;
    logic [31:0] acc_out, reg_out, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_lock, mem_ready, mem_rvalid;
    logic [1:0]  mem_size;

    cmpxchg_seq #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .dest_is_mem(dest_is_mem),
        .reg_dest(reg_dest), .src(src), .acc_in(acc_in), .addr(addr),
        .busy(busy), .done(done), .zf_out(zf_out), .cf_out(cf_out), .sf_out(sf_out),
        .of_out(of_out), .acc_we(acc_we), .acc_out(acc_out), .reg_we(reg_we),
        .reg_out(reg_out), .mem_req(mem_req), .mem_we(mem_we), .mem_lock(mem_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic zf, cf, sf, of, acc_we, reg_we;
        logic [31:0] acc_out, reg_out;
        int lat;
    } exp_t;
    typedef struct {
        logic we;
        logic [31:0] addr, data;
        logic [1:0] sz;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mem_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, n_done = 0;
    int mem_delay = 0, rvalid_delay = 0, wcnt = 0, rd_left = -1;
    logic [31:0] mem_word = '0;

    // acceptance seen at the last posedge
    logic        acc_seen = 0, acc_we_seen = 0, rst_seen = 0;
    logic [31:0] acc_addr = '0, acc_data = '0;
    logic [1:0]  acc_sz = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        acc_seen    <= mem_req & mem_ready & rst_n;
        acc_we_seen <= mem_we;
        acc_addr    <= mem_addr;
        acc_data    <= mem_wdata;
        acc_sz      <= mem_size;
        rst_seen    <= !rst_n;
    end

    // Memory model: ready after mem_delay stall cycles, rvalid rvalid_delay cycles after read acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready  = 0;
            mem_rvalid = 0;
            wcnt       = 0;
            rd_left    = -1;
        end else begin
            mem_rvalid = 0;
            if (acc_seen) begin
                if (mem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_mem_access: we=%0b addr=0x%08h expected no access", acc_we_seen, acc_addr);
                end else begin
                    mexp_t m;
                    m = mem_q.pop_front();
                    chk("mem_we", {31'b0, acc_we_seen}, {31'b0, m.we});
                    chk("mem_addr", acc_addr, m.addr);
                    chk("mem_size", {30'b0, acc_sz}, {30'b0, m.sz});
                    if (m.we) chk("mem_wdata", acc_data, m.data);
                end
                if (!acc_we_seen) rd_left = rvalid_delay;
            end
            if (rd_left == 0) begin
                mem_rvalid = 1;
                mem_rdata  = mem_word;
                rd_left    = -1;
            end else if (rd_left > 0) begin
                rd_left--;
            end
            if (mem_ready) mem_ready = 0;
            else if (mem_req) begin
                if (wcnt == mem_delay) begin
                    mem_ready = 1;
                    wcnt = 0;
                end else wcnt++;
            end
        end
    end

    // Lock continuity and request stability.
    logic        lock_window = 0, prev_req = 0, prev_we = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    always @(negedge clk) begin
        if (rst_seen) lock_window = 0;
        if (acc_seen && acc_we_seen) begin
            lock_window = 0;
            chk("lock_drop_after_write", {31'b0, mem_lock}, 32'd0);
        end
        if (lock_window || mem_req) chk("lock_held", {31'b0, mem_lock}, 32'd1);
        if (mem_req && !mem_we) lock_window = 1;
        if (prev_req && !acc_seen && !rst_seen) begin
            chk("req_held", {31'b0, mem_req}, 32'd1);
            chk("req_we_stable", {31'b0, mem_we}, {31'b0, prev_we});
            chk("req_addr_stable", mem_addr, prev_addr);
            chk("req_wdata_stable", mem_wdata, prev_wdata);
        end
        prev_req   = mem_req;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // Scoreboard monitor on done.
    logic busy_next_chk = 0;
    always @(negedge clk) begin
        if (busy_next_chk) begin
            chk("busy_after_done", {31'b0, busy}, 32'd0);
            busy_next_chk = 0;
        end
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: done=1 with no outstanding operation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", cyc - start_cyc, e.lat);
                chk("busy_in_done", {31'b0, busy}, 32'd1);
                chk("zf", {31'b0, zf_out}, {31'b0, e.zf});
                chk("cf", {31'b0, cf_out}, {31'b0, e.cf});
                chk("sf", {31'b0, sf_out}, {31'b0, e.sf});
                chk("of", {31'b0, of_out}, {31'b0, e.of});
                chk("acc_we", {31'b0, acc_we}, {31'b0, e.acc_we});
                chk("reg_we", {31'b0, reg_we}, {31'b0, e.reg_we});
                if (e.acc_we) chk("acc_out", acc_out, e.acc_out);
                if (e.reg_we) chk("reg_out", reg_out, e.reg_out);
            end
            busy_next_chk = 1;
        end
    end

    function automatic logic any_out();
        return busy | done | zf_out | cf_out | sf_out | of_out | acc_we | reg_we |
               mem_req | mem_we | mem_lock | (|acc_out) | (|reg_out) | (|mem_addr) |
               (|mem_wdata) | (|mem_size);
    endfunction

    task automatic launch(input bit is_mem, input logic [1:0] sz,
                          input logic [31:0] a, d, s, ad);
        @(posedge clk); #1;
        start       = 1;
        size        = sz;
        dest_is_mem = is_mem;
        acc_in      = a;
        src         = s;
        addr        = ad;
        reg_dest    = is_mem ? 32'hA5A5_A5A5 : d;
        if (is_mem) mem_word = d;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start    = 0;
        size     = ~sz;
        acc_in   = ~a;
        src      = ~s;
        addr     = ~ad;
        reg_dest = ~d;
    endtask

    task automatic issue(input bit is_mem, input logic [1:0] sz,
                         input logic [31:0] a, d, s, ad, input int dly,
                         input bit zf, cf, sf, of,
                         input logic [31:0] exp_acc, exp_reg, exp_wd,
                         input int lat, input bit extra);
        exp_t  e;
        mexp_t m;
        int target, guard;
        mem_delay = dly;
        e.zf = zf; e.cf = cf; e.sf = sf; e.of = of;
        e.acc_we = !zf; e.reg_we = zf && !is_mem;
        e.acc_out = exp_acc; e.reg_out = exp_reg; e.lat = lat;
        exp_q.push_back(e);
        if (is_mem) begin
            m.we = 0; m.addr = ad; m.data = '0; m.sz = sz;
            mem_q.push_back(m);
            m.we = 1; m.data = exp_wd;
            mem_q.push_back(m);
        end
        target = n_done + 1;
        launch(is_mem, sz, a, d, s, ad);
        if (extra) begin
            @(posedge clk); #1;
            start = 1; dest_is_mem = 0; size = 2'b00;
            acc_in = 32'h0; reg_dest = 32'h0; src = 32'h55;
            @(posedge clk); #1;
            start = 0;
        end
        guard = 0;
        while (n_done < target && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("done_within_bound", {31'b0, (n_done >= target)}, 32'd1);
    endtask

    initial begin
        rst_n = 0; start = 0; size = 0; dest_is_mem = 0;
        reg_dest = 0; src = 0; acc_in = 0; addr = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", {31'b0, any_out()}, 32'd0);
        @(posedge clk); #1 rst_n = 1;

        // register form, 32-bit, equal
        issue(0, 2'b10, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 0,
              1, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 2, 0);
        // register form, 8-bit: 0x10 - 0x20 = 0xF0
        issue(0, 2'b00, 32'hFFFF_FF10, 32'h0000_0020, 32'h0000_00AB, 32'h0, 0,
              0, 1, 1, 0, 32'h0000_0020, 32'h0, 32'h0, 2, 0);
        // register form, 16-bit: 0x8000 - 0x0001 = 0x7FFF signed overflow
        issue(0, 2'b01, 32'h0000_8000, 32'h0000_0001, 32'h0000_2222, 32'h0, 0,
              0, 0, 0, 1, 32'h0000_0001, 32'h0, 32'h0, 2, 0);
        // memory form, 16-bit, equal, 3 stall cycles on each request
        issue(1, 2'b01, 32'hABCD_8000, 32'h5555_8000, 32'hFFFF_1111, 32'h1000_0040, 3,
              1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_1111, 11, 0);
        // memory form, 32-bit, mismatch: 5 - 7, write of 7 still issued
        issue(1, 2'b10, 32'h0000_0005, 32'h0000_0007, 32'h0000_0099, 32'h0000_0020, 0,
              0, 1, 1, 0, 32'h0000_0007, 32'h0, 32'h0000_0007, 5, 0);

        // reset while in RD_WAIT
        begin
            mexp_t m;
            m.we = 0; m.addr = 32'h0000_0300; m.data = '0; m.sz = 2'b10;
            mem_q.push_back(m);
            mem_delay = 0;
            rvalid_delay = 20;
            launch(1, 2'b10, 32'h1, 32'h1, 32'h2, 32'h0000_0300);
            @(posedge clk);
            @(posedge clk); #1 rst_n = 0;
            @(negedge clk);
            chk("rd_wait_lock", {31'b0, mem_lock}, 32'd1);
            chk("rd_wait_busy", {31'b0, busy}, 32'd1);
            @(negedge clk);
            chk("abort_outputs_zero", {31'b0, any_out()}, 32'd0);
            @(posedge clk); #1 rst_n = 1;
            rvalid_delay = 0;
            repeat (4) @(posedge clk);
            chk("abort_no_write_pending", mem_q.size(), 32'd0);
        end

        // register form after reset, 8-bit: 0x7F - 0xFF = 0x80 with borrow and overflow
        issue(0, 2'b00, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0001, 32'h0, 0,
              0, 1, 1, 1, 32'h0000_00FF, 32'h0, 32'h0, 2, 0);
        // memory form, size 11 as 32-bit: 0x100 vs 0 differ; second start ignored
        issue(1, 2'b11, 32'h0000_0100, 32'h0000_0000, 32'h0000_0003, 32'h0000_0044, 0,
              0, 0, 0, 0, 32'h0000_0000, 32'h0, 32'h0000_0000, 5, 1);

        repeat (6) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("mem_expect_drained", mem_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
